// File: rtl/apb4_master_bridge.sv
// apb4_master_bridge: single-outstanding APB4 initiator.
// Accepts one command on a valid/ready stream, runs an APB4 SETUP/ACCESS
// transfer, and returns read data and error status on a valid/ready
// response stream.
// Optional ACCESS watchdog: define APB4_MASTER_TIMEOUT_EN to build it.
module apb4_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                  pclk,
  input  logic                  presetn,
  // command stream
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]            cmd_strb,
  input  logic [2:0]            cmd_prot,
  // response stream
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  // APB4 master port
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [2:0]            pprot,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [3:0]            pstrb,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state_reg;

  // Ready only when idle; forced low while reset is asserted so no command
  // can be mistaken as accepted during reset.
  assign cmd_ready = presetn && (state_reg == IDLE);

`ifdef APB4_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Abort on the TIMEOUT-th stalled ACCESS cycle, i.e. when the count would
  // reach TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] wait_cnt_reg;
`else
  assign rsp_timeout = 1'b0;
`endif

  // Transfer sequencer; all APB and response outputs are registered here.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_reg <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= 4'b0000;
      pprot     <= 3'b000;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB4_MASTER_TIMEOUT_EN
      rsp_timeout  <= 1'b0;
      wait_cnt_reg <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            paddr     <= cmd_addr;
            pwrite    <= cmd_write;
            pwdata    <= cmd_wdata;
            pprot     <= cmd_prot;
            // Reads never carry strobes on APB4.
            pstrb     <= cmd_write ? cmd_strb : 4'b0000;
            psel      <= 1'b1;
            penable   <= 1'b0;
            state_reg <= SETUP;
          end
        end
        SETUP: begin
          penable   <= 1'b1;
          state_reg <= ACCESS;
`ifdef APB4_MASTER_TIMEOUT_EN
          wait_cnt_reg <= '0;
`endif
        end
        ACCESS: begin
          // A slave completion wins over a watchdog expiry in the same cycle.
          if (pready) begin
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslverr;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            state_reg <= RESP;
`ifdef APB4_MASTER_TIMEOUT_EN
            rsp_timeout <= 1'b0;
          end else if (wait_cnt_reg == CNT_LAST) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            state_reg   <= RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Directed, self-checking bench for apb4_master_bridge with a response
// scoreboard and a simple configurable APB4 slave.
module tb_apb4_master_bridge;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;

  // slave model configuration
  int          wait_cfg  = 0;
  logic        hang      = 1'b0;
  logic [31:0] slv_data  = '0;
  logic        slv_err   = 1'b0;
  int          acc_cnt   = 0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;
  exp_t sb[$];

  apb4_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // Slave: ready after wait_cfg stalled ACCESS cycles; junk data otherwise.
  assign pready  = psel && penable && !hang && (acc_cnt >= wait_cfg);
  assign prdata  = pready ? slv_data : 32'hDEAD_BEEF;
  assign pslverr = pready ? slv_err : 1'b1;

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command; returns at the negedge of the cycle after acceptance.
  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] strb, input logic [2:0] prot);
    bit ok = 0;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = strb; cmd_prot = prot;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(negedge pclk);
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $error("FAIL send_timeout: observed cmd_ready 0 expected 1");
    end
    @(negedge pclk);
    cmd_valid = 1'b0;
    $display("cmd  wr=%0d addr=%08h wdata=%08h strb=%h prot=%0d", wr, addr, wd, strb, prot);
  endtask

  // Count ACCESS cycles until rsp_valid rises (starts in SETUP).
  task automatic measure_access(output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge pclk);
      if (psel && penable) n++;
      if (rsp_valid) break;
    end
  endtask

  // Wait for a response, compare against scoreboard, then handshake.
  task automatic get_rsp(input string tag);
    exp_t e;
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (rsp_valid) begin ok = 1; break; end
      @(negedge pclk);
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $error("FAIL %s_rsp_valid: observed 0 expected 1", tag);
      return;
    end
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL %s_scoreboard: observed empty expected entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
    chk({tag, "_err"}, 64'(rsp_err), 64'(e.err));
    chk({tag, "_timeout"}, 64'(rsp_timeout), 64'(e.tmo));
    $display("rsp  %s rdata=%08h err=%0d timeout=%0d", tag, rsp_rdata, rsp_err, rsp_timeout);
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_valid_clr"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    int n;
    logic [31:0] held;
    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;

    // ---- reset state
    repeat (3) @(negedge pclk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_penable", 64'(penable), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_pstrb", 64'(pstrb), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    presetn = 1'b1;
    @(negedge pclk);
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // ---- write, zero wait states, cycle-exact timing
    wait_cfg = 0; slv_data = 32'h5555_AAAA; slv_err = 1'b0;
    sb.push_back('{rdata: 32'h0, err: 1'b0, tmo: 1'b0});
    send(1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF, 3'd0);
    chk("wr_setup_psel", 64'(psel), 64'd1);
    chk("wr_setup_penable", 64'(penable), 64'd0);
    chk("wr_setup_cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge pclk);
    chk("wr_access_penable", 64'(penable), 64'd1);
    chk("wr_access_pwrite", 64'(pwrite), 64'd1);
    chk("wr_access_pstrb", 64'(pstrb), 64'hF);
    chk("wr_access_paddr", 64'(paddr), 64'h4);
    chk("wr_access_pwdata", 64'(pwdata), 64'h1234_5678);
    @(negedge pclk);
    chk("wr_t3_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("wr_t3_psel", 64'(psel), 64'd0);
    get_rsp("wr0");

    // ---- read with 3 wait states
    wait_cfg = 3; slv_data = 32'hFFFF_FFFF;
    sb.push_back('{rdata: 32'hFFFF_FFFF, err: 1'b0, tmo: 1'b0});
    send(1'b0, 32'h0000_0008, 32'h0BAD_0BAD, 4'hF, 3'd2);
    chk("rd_pstrb", 64'(pstrb), 64'd0);
    chk("rd_pwrite", 64'(pwrite), 64'd0);
    measure_access(n);
    chk("rd_access_len", 64'(n), 64'd4);
    get_rsp("rd_ws3");

    // ---- read with slave error; response stalled 5 cycles with a command waiting
    wait_cfg = 1; slv_data = 32'hA5A5_0001; slv_err = 1'b1;
    sb.push_back('{rdata: 32'hA5A5_0001, err: 1'b1, tmo: 1'b0});
    send(1'b0, 32'h0000_000C, 32'h0, 4'h0, 3'd1);
    measure_access(n);
    chk("err_access_len", 64'(n), 64'd2);
    slv_err = 1'b0;
    cmd_write = 1'b1; cmd_addr = 32'h0000_0010; cmd_wdata = 32'hCAFE_F00D;
    cmd_strb = 4'h3; cmd_prot = 3'd5; cmd_valid = 1'b1;
    held = rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      chk("stall_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("stall_psel", 64'(psel), 64'd0);
      chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("stall_rsp_rdata", 64'(rsp_rdata), 64'(held));
    end
    get_rsp("rd_err");
    chk("after_hs_cmd_ready", 64'(cmd_ready), 64'd1);

    // ---- pending write issued once the handshake freed the bridge
    wait_cfg = 0;
    sb.push_back('{rdata: 32'h0, err: 1'b0, tmo: 1'b0});
    send(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'h3, 3'd5);
    chk("wr1_pstrb", 64'(pstrb), 64'h3);
    chk("wr1_pprot", 64'(pprot), 64'd5);
    get_rsp("wr1");

    // ---- stalled slave: watchdog abort or indefinite wait
    hang = 1'b1; slv_data = 32'h1111_2222;
`ifdef APB4_MASTER_TIMEOUT_EN
    sb.push_back('{rdata: 32'h0, err: 1'b1, tmo: 1'b1});
    send(1'b0, 32'h0000_0020, 32'h0, 4'h0, 3'd0);
    measure_access(n);
    chk("tmo_access_len", 64'(n), 64'd4);
    get_rsp("tmo");
    send(1'b0, 32'h0000_0024, 32'h0, 4'h0, 3'd0);
    @(negedge pclk);
`else
    send(1'b0, 32'h0000_0020, 32'h0, 4'h0, 3'd0);
    repeat (110) @(negedge pclk);
    chk("hang_penable", 64'(penable), 64'd1);
    chk("hang_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("hang_rsp_timeout", 64'(rsp_timeout), 64'd0);
`endif

    // ---- reset during ACCESS
    chk("pre_rst_psel", 64'(psel), 64'd1);
    chk("pre_rst_penable", 64'(penable), 64'd1);
    presetn = 1'b0;
    @(negedge pclk);
    chk("mid_rst_psel", 64'(psel), 64'd0);
    chk("mid_rst_penable", 64'(penable), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    presetn = 1'b1; hang = 1'b0;
    @(negedge pclk);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // ---- recovery read after reset
    wait_cfg = 2; slv_data = 32'h0BAD_CAFE;
    sb.push_back('{rdata: 32'h0BAD_CAFE, err: 1'b0, tmo: 1'b0});
    send(1'b0, 32'h0000_0030, 32'h0, 4'h0, 3'd0);
    get_rsp("rd_post_rst");
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
